fp_div_seq: RTL and testbench

- Iterative IEEE-754 half-precision divider computing a/b. It is the sequential counterpart to the FPU's combinational multiplier.
- Fills the FPU's division opcode (2'b11) slot.
- Uses a valid/ready handshake on both ends.
- Returns the FPU's 6-bit flag vector {snan,qnan,infinity,zero,subnormal,normal} alongside the 16-bit result.

---
 rtl/fpu_pkg.sv | 51 +++++
 rtl/fp_unpack.sv | 50 +++++
 rtl/fp_div_seq.sv | 197 +++++++++++++++++++
 tb/tb_fp_div_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared fp16 field layout, flag indices, canonical constants and divider FSM states.
package fpu_pkg;

    localparam int FP16_W     = 16;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int SIGN_BIT   = 15;
    localparam int EXP_LSB    = 10;
    localparam int EXP_MSB    = 14;

    localparam int FLAG_SNAN   = 5;
    localparam int FLAG_QNAN   = 4;
    localparam int FLAG_INF    = 3;
    localparam int FLAG_ZERO   = 2;
    localparam int FLAG_SUB    = 1;
    localparam int FLAG_NORMAL = 0;

    localparam logic [15:0] QNAN_VAL = 16'h7E00;
    localparam logic [15:0] INF_VAL  = 16'h7C00;

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;

    // expo is the biased exponent after normalisation; subnormals go below 1.
    typedef struct packed {
        logic              sign;
        logic signed [7:0] expo;
        logic [10:0]       man;
        logic              zero;
        logic              sub;
        logic              norm;
        logic              inf;
        logic              qnan;
        logic              snan;
    } unpacked_t;

    // Class flags of a non-NaN fp16 magnitude; exactly one of bits [3:0] is set.
    function automatic logic [5:0] classify(input logic [14:0] m);
        logic [5:0] f;
        f = '0;
        if (m[14:10] == 5'h1F) begin
            f[FLAG_INF] = 1'b1;
        end else if (m[14:10] == 5'h00) begin
            if (m[9:0] == 10'h000) f[FLAG_ZERO] = 1'b1;
            else                   f[FLAG_SUB]  = 1'b1;
        end else begin
            f[FLAG_NORMAL] = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Classifies one fp16 operand and normalises subnormals so man[10] is always set.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module fp_unpack
    import fpu_pkg::*;
(
    input  logic [15:0] x,
    output unpacked_t   u
);

    logic [4:0]  ef;
    logic [9:0]  mf;
    logic [3:0]  lz;
    logic [10:0] sh;

    always_comb begin
        ef = x[EXP_MSB:EXP_LSB];
        mf = x[EXP_LSB-1:0];

        // Highest set bit wins: leading zeros of {1'b0, mf}.
        lz = 4'd0;
        for (int i = 0; i < FP16_MAN_W; i++) begin
            if (mf[i]) lz = 4'(FP16_MAN_W - i);
        end
        sh = {1'b0, mf} << lz;

        u      = '0;
        u.sign = x[SIGN_BIT];
        if (ef == 5'h1F) begin
            u.inf  = (mf == 10'h000);
            u.qnan = (mf != 10'h000) && mf[9];
            u.snan = (mf != 10'h000) && !mf[9];
            u.expo = 8'sd31;
            u.man  = {1'b1, mf};
        end else if (ef == 5'h00) begin
            if (mf == 10'h000) begin
                u.zero = 1'b1;
            end else begin
                u.sub  = 1'b1;
                u.expo = 8'sd1 - $signed({4'b0000, lz});
                u.man  = sh;
            end
        end else begin
            u.norm = 1'b1;
            u.expo = $signed({3'b000, ef});
            u.man  = {1'b1, mf};
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative fp16 divider a/b with RNE; SUBNORMAL_OUT_EN keeps subnormal quotients instead of flushing.
// Latency: out_valid in the 15th cycle after accept (finite path), 2nd cycle for special operands.
// Backpressure: single-entry; result held until out_ready, no accept while busy.
module fp_div_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W = FP16_EXP_W,
    parameter int MAN_W = FP16_MAN_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out,
    output logic [5:0]  out_flag
);

    localparam int ITER  = MAN_W + 2;
    localparam int SIG_W = MAN_W + 1;
    localparam int REM_W = MAN_W + 2;
    localparam int EMAX  = (1 << EXP_W) - 1;

    state_t             state;
    logic [15:0]        a_r;
    logic [15:0]        b_r;
    logic               sign_r;
    logic signed [7:0]  e_r;
    logic [REM_W-1:0]   rem;
    logic [SIG_W-1:0]   div_r;
    logic [SIG_W-1:0]   q;
    logic [3:0]         cnt;

    unpacked_t ua;
    unpacked_t ub;

    fp_unpack u_unpack_a (.x(a_r), .u(ua));
    fp_unpack u_unpack_b (.x(b_r), .u(ub));

    assign in_ready = (state == IDLE);

    // Operand classification and special-case results, valid in UNPACK.
    logic              finite_both;
    logic              nan_case;
    logic              invalid_op;
    logic              inf_case;
    logic              sign_x;
    logic              pre;
    logic signed [7:0] e_pre;
    logic [15:0]       spec_res;
    logic [5:0]        spec_flag;

    always_comb begin
        sign_x      = ua.sign ^ ub.sign;
        finite_both = (ua.sub | ua.norm) & (ub.sub | ub.norm);
        invalid_op  = (ua.zero & ub.zero) | (ua.inf & ub.inf);
        nan_case    = ua.qnan | ua.snan | ub.qnan | ub.snan | invalid_op;
        inf_case    = ua.inf | ub.zero;
        pre         = (ua.man < ub.man);
        e_pre       = ua.expo - ub.expo + 8'sd15 - (pre ? 8'sd1 : 8'sd0);

        spec_flag = '0;
        if (nan_case) begin
            spec_res             = QNAN_VAL;
            spec_flag[FLAG_QNAN] = 1'b1;
            spec_flag[FLAG_SNAN] = ua.snan | ub.snan | invalid_op;
        end else if (inf_case) begin
            spec_res            = INF_VAL | {sign_x, 15'h0000};
            spec_flag[FLAG_INF] = 1'b1;
        end else begin
            spec_res             = {sign_x, 15'h0000};
            spec_flag[FLAG_ZERO] = 1'b1;
        end
    end

    // One restoring step per DIVIDE cycle; the leading quotient bit always
    // shifts out of q because pre-alignment pins it to 1.
    logic             ge;
    logic [REM_W-1:0] rem_sub;
    logic [REM_W-1:0] rem_next;
    logic [SIG_W-1:0] q_next;

    always_comb begin
        ge       = (rem >= {1'b0, div_r});
        rem_sub  = ge ? (rem - {1'b0, div_r}) : rem;
        rem_next = {rem_sub[REM_W-2:0], 1'b0};
        q_next   = {q[SIG_W-2:0], ge};
    end

`ifdef SUBNORMAL_OUT_EN
    logic signed [7:0] s8;
    logic [4:0]        sh_amt;
    logic [35:0]       vec;
    logic [10:0]       field;

    always_comb begin
        s8     = 8'sd1 - e_r;
        sh_amt = (s8 > 8'sd25) ? 5'd25 : s8[4:0];
        vec    = {1'b1, q, 24'h000000} >> sh_amt;
        field  = vec[35:25];
    end
`endif

    logic        sticky;
    logic        up;
    logic [14:0] mag;
    logic [15:0] rnd_res;
    logic [5:0]  rnd_flag;

    always_comb begin
        sticky = |rem;
        up     = 1'b0;
        mag    = '0;
        if (e_r >= EMAX) begin
            mag = INF_VAL[14:0];
        end else if (e_r >= 1) begin
            // A mantissa carry ripples into the exponent field, reaching inf at the top.
            up  = q[0] & (sticky | q[1]);
            mag = {e_r[EXP_W-1:0], q[MAN_W:1]} + 15'(up);
        end else begin
`ifdef SUBNORMAL_OUT_EN
            up  = vec[24] & ((|vec[23:0]) | sticky | field[0]);
            mag = 15'(field) + 15'(up);
`else
            mag = '0;
`endif
        end
        rnd_res  = {sign_r, mag};
        rnd_flag = classify(mag);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            sign_r    <= 1'b0;
            e_r       <= '0;
            rem       <= '0;
            div_r     <= '0;
            q         <= '0;
            cnt       <= '0;
            out       <= '0;
            out_flag  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_r <= sign_x;
                    if (!finite_both) begin
                        out       <= spec_res;
                        out_flag  <= spec_flag;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rem   <= pre ? {ua.man, 1'b0} : {1'b0, ua.man};
                        div_r <= ub.man;
                        e_r   <= e_pre;
                        q     <= '0;
                        cnt   <= '0;
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem <= rem_next;
                    q   <= q_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(ITER - 1)) state <= ROUND;
                end
                ROUND: begin
                    out       <= rnd_res;
                    out_flag  <= rnd_flag;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed-vector bench for fp_div_seq: results, flags, latency, backpressure and async reset abort.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out;
    logic [5:0]  out_flag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_flag  (out_flag)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] va, input logic [15:0] vb);
        @(negedge clk);
        check("idle_in_ready", 16'(in_ready), 16'd1);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the accept edge; bounded at 40.
    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] exp_out, input logic [5:0] exp_flag, input int exp_lat);
        int lat;
        start_op(va, vb);
        wait_out(lat);
        check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
        check({tag, "_out"}, out, exp_out);
        check({tag, "_flag"}, 16'(out_flag), 16'(exp_flag));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out", out, 16'h0000);
        check("rst_out_flag", 16'(out_flag), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 16'(in_ready), 16'd1);

        // Finite path
        run_op("two_div_one",  16'h4000, 16'h3C00, 16'h4000, 6'b000001, 15);
        run_op("one_third",    16'h3C00, 16'h4200, 16'h3555, 6'b000001, 15);
        run_op("one_seventh",  16'h3C00, 16'h4700, 16'h3092, 6'b000001, 15);
        run_op("round_up",     16'h3C00, 16'h3BFF, 16'h3C01, 6'b000001, 15);
        run_op("neg_quot",     16'hC000, 16'h4000, 16'hBC00, 6'b000001, 15);
        run_op("sub_by_sub",   16'h0001, 16'h0001, 16'h3C00, 6'b000001, 15);
        run_op("overflow",     16'h7BFF, 16'h0001, 16'h7C00, 6'b001000, 15);
`ifdef SUBNORMAL_OUT_EN
        run_op("underflow",    16'h0400, 16'h4800, 16'h0080, 6'b000010, 15);
`else
        run_op("underflow",    16'h0400, 16'h4800, 16'h0000, 6'b000100, 15);
`endif

        // Special operands
        run_op("one_div_zero", 16'h3C00, 16'h0000, 16'h7C00, 6'b001000, 2);
        run_op("neg_div_zero", 16'hBC00, 16'h0000, 16'hFC00, 6'b001000, 2);
        run_op("zero_zero",    16'h0000, 16'h0000, 16'h7E00, 6'b110000, 2);
        run_op("snan_in",      16'h7C01, 16'h3C00, 16'h7E00, 6'b110000, 2);
        run_op("qnan_in",      16'h7E00, 16'h3C00, 16'h7E00, 6'b010000, 2);
        run_op("fin_div_inf",  16'h3C00, 16'h7C00, 16'h0000, 6'b000100, 2);
        run_op("inf_div_fin",  16'h7C00, 16'h4000, 16'h7C00, 6'b001000, 2);

        // Backpressure: result held, busy input ignored
        start_op(16'h4400, 16'h4000);
        wait_out(lat);
        check("bp_lat", 16'(lat), 16'd15);
        check("bp_out", out, 16'h4000);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a        = 16'h3C00;
            b        = 16'h0000;
            @(negedge clk);
            check("bp_hold_out", out, 16'h4000);
            check("bp_hold_flag", 16'(out_flag), 16'h0001);
            check("bp_hold_valid", 16'(out_valid), 16'd1);
            check("bp_in_ready", 16'(in_ready), 16'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_valid_drop", 16'(out_valid), 16'd0);
        @(negedge clk);
        check("bp_ready_back", 16'(in_ready), 16'd1);
        run_op("b2b_0", 16'h4200, 16'h3C00, 16'h4200, 6'b000001, 15);
        run_op("b2b_1", 16'hC400, 16'h4000, 16'hC000, 6'b000001, 15);

        // Asynchronous reset while dividing
        run_op("pre_rst", 16'h4000, 16'h3C00, 16'h4000, 6'b000001, 15);
        start_op(16'h3C00, 16'h4200);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", 16'(out_valid), 16'd0);
        check("abort_out", out, 16'h0000);
        check("abort_flag", 16'(out_flag), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 16'(in_ready), 16'd1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_output", 16'(seen), 16'd0);
        run_op("post_rst", 16'h4400, 16'h4000, 16'h4000, 6'b000001, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
